pkt_framer: RTL and testbench

- Upstream stage of the packet-checking FSM/parameterized mux.
- Accepts raw payload words over a valid/ready handshake and buffers them in a small FIFO.
- Frames each word into a BUS_SIZE bus word: a sequence number in the MSW, payload in the middle, and the 0xF marker in the LSW.
- Has one-shot error-injection controls so the downstream checker's F_ERROR and SEQ_ERROR paths can be exercised.

---
 rtl/pkt_framer_pkg.sv | 14 +
 rtl/pkt_framer_pay_fifo.sv | 48 ++++
 rtl/pkt_framer.sv | 131 +++++++++++++
 tb/tb_pkt_framer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_framer_pkg.sv
// Shared definitions for the packet framer and the downstream packet checker.
package pkt_framer_pkg;

  // Framer FSM states; the checker decodes the same encodings.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    STREAM = 2'd2
  } fr_state_t;

  // Marker carried in the least significant word of every good beat.
  localparam logic [3:0] LSW_MARKER = 4'hF;

endpackage

// File: rtl/pkt_framer_pay_fifo.sv
// Synchronous payload FIFO with async active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pay_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pkt_framer.sv
// Packet framer: buffers payload words and frames each one as
// {sequence, payload, marker}, with one-shot error injection for the checker.
module pkt_framer
  import pkt_framer_pkg::*;
#(
  parameter  int BUS_SIZE   = 16,
  parameter  int WORD_SIZE  = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int WORD_NUM   = BUS_SIZE / WORD_SIZE,
  localparam int PAY_SIZE   = (WORD_NUM - 2) * WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PAY_SIZE-1:0] pay_data_in,
  input  logic                pay_valid,
  output logic                pay_ready,
  input  logic                inj_f_err,
  input  logic                inj_seq_err,
  output logic [BUS_SIZE-1:0] bus_data_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                first_pkt,
  output logic [1:0]          state_out,
  output logic [7:0]          pkt_count
);

  localparam logic [WORD_SIZE-1:0] LSW_OK = WORD_SIZE'(LSW_MARKER);

  fr_state_t             state_q, state_d;
  logic [PAY_SIZE-1:0]   fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  load;
  logic                  xfer;
  logic                  out_free;
  logic                  f_pend;
  logic                  s_pend;
  logic [WORD_SIZE-1:0]  seq_q;
  logic [WORD_SIZE-1:0]  seq_used;
  logic [WORD_SIZE-1:0]  lsw;

  assign pay_ready = ~fifo_full;
  assign push      = pay_valid & ~fifo_full;
  assign xfer      = out_valid & out_ready;
  assign out_free  = ~out_valid | out_ready;
  assign load      = enable & ~fifo_empty & out_free;
  assign seq_used  = s_pend ? seq_q + WORD_SIZE'(1) : seq_q;
  assign lsw       = f_pend ? '0 : LSW_OK;
  assign state_out = state_q;

  pay_fifo #(
    .WIDTH (PAY_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (load),
    .wr_data (pay_data_in),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a load advances IDLE->FIRST->STREAM; disabling with an
  // empty output register returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (load) state_d = FIRST;
      FIRST: begin
        if (load)                       state_d = STREAM;
        else if (!enable && (!out_valid || xfer)) state_d = IDLE;
      end
      STREAM: if (!enable && (!out_valid || xfer)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register: load a framed beat, drop valid after a transfer, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_data_out <= '0;
      out_valid    <= 1'b0;
      first_pkt    <= 1'b0;
    end else if (load) begin
      bus_data_out <= {seq_used, fifo_data, lsw};
      out_valid    <= 1'b1;
      first_pkt    <= (state_q == IDLE);
    end else if (xfer) begin
      out_valid    <= 1'b0;
      first_pkt    <= 1'b0;
    end
  end

  // Sequence counter: advances past the value used, restarts on entering IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    seq_q <= '0;
    else if (load)                                seq_q <= seq_used + WORD_SIZE'(1);
    else if (state_d == IDLE && state_q != IDLE)  seq_q <= '0;
  end

  // Injection flags: a pulse coinciding with a load is kept for the next beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pend <= 1'b0;
      s_pend <= 1'b0;
    end else if (load) begin
      f_pend <= inj_f_err;
      s_pend <= inj_seq_err;
    end else begin
      f_pend <= f_pend | inj_f_err;
      s_pend <= s_pend | inj_seq_err;
    end
  end

  // Count of transferred beats, wrapping at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pkt_count <= '0;
    else if (xfer) pkt_count <= pkt_count + 8'd1;
  end

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboard bench for pkt_framer: pushes tagged payloads, monitor rebuilds beats.
module tb_pkt_framer;

  localparam int BUS = 16;
  localparam int PS  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [PS-1:0] pay_data_in = '0;
  logic          pay_valid = 1'b0;
  logic          pay_ready;
  logic          inj_f_err = 1'b0;
  logic          inj_seq_err = 1'b0;
  logic [BUS-1:0] bus_data_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          first_pkt;
  logic [1:0]    state_out;
  logic [7:0]    pkt_count;

  pkt_framer #(
    .BUS_SIZE   (16),
    .WORD_SIZE  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pay_data_in  (pay_data_in),
    .pay_valid    (pay_valid),
    .pay_ready    (pay_ready),
    .inj_f_err    (inj_f_err),
    .inj_seq_err  (inj_seq_err),
    .bus_data_out (bus_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .first_pkt    (first_pkt),
    .state_out    (state_out),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PS-1:0] pay;
    bit            f;
    bit            s;
    bit            starts;
  } exp_t;

  exp_t sb[$];
  int   xcyc[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   mon_seq = 0;
  int   mon_cnt = 0;
  int   ready_mode = 1;  // 0 low, 1 high, 2 random
  bit   pend_f = 0;
  bit   pend_s = 0;
  bit   next_starts = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready, updated shortly after each edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every transfer pops one expectation and rebuilds the framed word.
  initial begin
    exp_t           e;
    int             su;
    logic [3:0]     sq;
    logic [3:0]     lw;
    logic [BUS-1:0] eb;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(bus_data_out), 32'hFFFF_FFFF);
        end else begin
          e  = sb.pop_front();
          su = ((e.starts ? 0 : mon_seq) + (e.s ? 1 : 0)) % 16;
          mon_seq = (su + 1) % 16;
          sq = su[3:0];
          lw = e.f ? 4'h0 : 4'hF;
          eb = {sq, e.pay, lw};
          check("beat_data", 32'(bus_data_out), 32'(eb));
          check("beat_first", 32'(first_pkt), 32'(e.starts));
          check("pkt_count", 32'(pkt_count), 32'(mon_cnt));
          mon_cnt = (mon_cnt + 1) % 256;
          xcyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_state", 32'(state_out), 0);
    check("rst_pay_ready", 32'(pay_ready), 1);
    check("rst_bus", 32'(bus_data_out), 0);
    check("rst_first", 32'(first_pkt), 0);
    check("rst_count", 32'(pkt_count), 0);
    sb.delete();
    mon_cnt = 0;
    pend_f = 0;
    pend_s = 0;
    next_starts = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [PS-1:0] d);
    exp_t e;
    int   t;
    bit   ok;
    t = 0;
    ok = 0;
    pay_valid = 1'b1;
    pay_data_in = d;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (pay_ready) ok = 1;
      else t++;
    end
    if (!ok) begin
      check("push_timeout", 0, 1);
      pay_valid = 1'b0;
      return;
    end
    e.pay = d;
    e.f = pend_f;
    e.s = pend_s;
    e.starts = next_starts;
    pend_f = 0;
    pend_s = 0;
    next_starts = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pay_valid = 1'b0;
  endtask

  // Only issued with the pipeline drained, so the flags belong to the next push.
  task automatic pulse(input bit f, input bit s);
    inj_f_err = f;
    inj_seq_err = s;
    step();
    inj_f_err = 1'b0;
    inj_seq_err = 1'b0;
    if (f) pend_f = 1;
    if (s) pend_s = 1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 0);
    step();
  endtask

  logic [PS-1:0] w0;

  initial begin
    do_reset();

    // Single beat latency and framing.
    ready_mode = 1;
    enable = 1'b1;
    step();
    push(8'hAB);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 1);
    check("lat_bus", 32'(bus_data_out), 32'h0ABF);
    check("lat_first", 32'(first_pkt), 1);
    check("lat_state", 32'(state_out), 1);
    drain();

    // Sequence wrap and full throughput.
    do_reset();
    enable = 1'b1;
    xcyc.delete();
    for (int i = 0; i < 20; i++) push(8'($urandom));
    @(negedge clk);
    check("wrap_state", 32'(state_out), 2);
    drain();
    @(negedge clk);
    check("wrap_count", 32'(pkt_count), 20);
    check("wrap_beats", 32'(xcyc.size()), 20);
    if (xcyc.size() == 20) check("wrap_rate", 32'(xcyc[19] - xcyc[0]), 19);
    step();

    // Backpressure: four in the FIFO plus one held at the output.
    do_reset();
    ready_mode = 0;
    enable = 1'b1;
    step();
    w0 = 8'($urandom);
    push(w0);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full", 32'(pay_ready), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_bus", 32'(bus_data_out), 32'({4'h0, w0, 4'hF}));
    end
    step();
    ready_mode = 1;
    push(8'($urandom));
    drain();

    // Injection: f then seq after three beats, then both, then repeated f.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    drain();
    pulse(1, 0);
    push(8'h11);
    drain();
    pulse(0, 1);
    push(8'h22);
    push(8'h33);
    drain();
    pulse(1, 1);
    push(8'h44);
    drain();
    pulse(1, 0);
    pulse(1, 0);
    push(8'h55);
    push(8'h66);
    drain();

    // Enable drop with a held beat and two words buffered.
    ready_mode = 0;
    step();
    for (int i = 0; i < 3; i++) push(8'($urandom));
    enable = 1'b0;
    if (sb.size() > 1) sb[1].starts = 1;
    @(negedge clk);
    check("dis_hold", 32'(out_valid), 1);
    step();
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("dis_idle", 32'(state_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dis_no_load", 32'(out_valid), 0);
      check("dis_fifo_kept", 32'(sb.size()), 2);
    end
    step();
    enable = 1'b1;
    drain();

    // Random bursts with random backpressure and occasional injections.
    ready_mode = 2;
    for (int b = 0; b < 30; b++) begin
      drain();
      if ($urandom_range(0, 3) == 0) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        push(8'($urandom));
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      end
    end
    drain();

    // Reset mid-operation, then a fresh first beat.
    ready_mode = 0;
    step();
    for (int i = 0; i < 3; i++) push(8'($urandom));
    do_reset();
    ready_mode = 1;
    enable = 1'b1;
    push(8'h5A);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
